// File: rtl/usr_shift_sequencer.sv
// -----------------------------------------------------------------------------
// usr_shift_sequencer
//
// Purpose:
//   Drives one universal shift register (USR) through its ctrl/data pins to run
//   a job {word, direction, shift count}:
//     1. parallel-load the word,
//     2. shift it count times,
//     3. hold for one settle cycle,
//     4. capture the USR output and present it on a valid/ready result port.
//   The USR shares clk with this block. Its dout is registered and updates on
//   the edge that ends each ctrl cycle.
//
// Parameters:
//   WIDTH - USR word width (in_data, usr_data, usr_dout, out_data)
//   CNT_W - width of in_count; the largest shift count is 2**CNT_W-1
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-low reset
//   in_valid  in   job request
//   in_ready  out  high only in IDLE; a job is accepted on in_valid && in_ready
//   in_data   in   word to load
//   in_dir    in   0 = shift right (toward bit 0), 1 = shift left
//   in_count  in   number of shift cycles; 0 is legal
//   usr_ctrl  out  USR ctrl: 0 hold, 1 shift right, 2 shift left, 3 load
//   usr_data  out  USR parallel data; holds the job word, and is 0 in IDLE
//   usr_dout  in   USR registered output
//   out_valid out  result available
//   out_ready in   result consumed on out_valid && out_ready
//   out_data  out  captured USR word
//   busy      out  high in every state except IDLE
//   err       out  sticky shadow-check error
//
// Configuration:
//   USR_SEQ_CHECK_EN - when defined, a shadow copy of the USR word is loaded
//   and shifted (zero-filling) in step with usr_ctrl. During SETTLE, any
//   difference between usr_dout and the shadow copy sets err. err stays set
//   until reset. When the macro is undefined, err is tied to 0.
//
// All outputs are decoded from registered state and registered job fields, so
// no output depends combinationally on an input.
// -----------------------------------------------------------------------------
module usr_shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic [CNT_W-1:0] in_count,
   output logic [1:0]       usr_ctrl,
   output logic [WIDTH-1:0] usr_data,
   input  logic [WIDTH-1:0] usr_dout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SHIFT  = 3'd2,
      S_SETTLE = 3'd3,
      S_OUT    = 3'd4
   } state_t;

   localparam logic [1:0] CTRL_HOLD  = 2'd0;
   localparam logic [1:0] CTRL_SHR   = 2'd1;
   localparam logic [1:0] CTRL_SHL   = 2'd2;
   localparam logic [1:0] CTRL_LOAD  = 2'd3;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic               dir_q, dir_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;

   // Next-state and job-field logic
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      dir_d      = dir_q;
      rem_d      = rem_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               word_d  = in_data;
               dir_d   = in_dir;
               rem_d   = in_count;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = (rem_q != '0) ? S_SHIFT : S_SETTLE;
         end
         S_SHIFT: begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // usr_dout already reflects the last shift edge here
            out_data_d = usr_dout;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
      end
   end

   // Job fields are only consumed outside IDLE, so they need no reset
   always_ff @(posedge clk) begin
      word_q <= word_d;
      dir_q  <= dir_d;
      rem_q  <= rem_d;
   end

   // Output decode from registered state
   always_comb begin
      usr_ctrl = CTRL_HOLD;
      case (state_q)
         S_LOAD:  usr_ctrl = CTRL_LOAD;
         S_SHIFT: usr_ctrl = dir_q ? CTRL_SHL : CTRL_SHR;
         default: usr_ctrl = CTRL_HOLD;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign usr_data  = (state_q == S_IDLE) ? '0 : word_q;
   assign out_data  = out_data_q;

`ifdef USR_SEQ_CHECK_EN
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             err_q, err_d;

   // The shadow moves on the same edges as the USR, so in SETTLE it holds
   // the word the USR should present.
   always_comb begin
      shadow_d = shadow_q;
      err_d    = err_q;
      case (usr_ctrl)
         CTRL_LOAD: shadow_d = word_q;
         CTRL_SHR:  shadow_d = shadow_q >> 1;
         CTRL_SHL:  shadow_d = shadow_q << 1;
         default:   shadow_d = shadow_q;
      endcase
      if ((state_q == S_SETTLE) && (usr_dout != shadow_q)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
